// File: rtl/eyetracker_pkg.sv
// Shared definitions for the eye-tracker pipeline.
// Holds the scanner FSM state encoding, default geometry and width
// constants, and width helpers for the per-chunk popcount and weight sum.
package eyetracker_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StPublish
    } state_e;

    localparam int unsigned DefMdataWidth = 640;
    localparam int unsigned DefScanWidth  = 32;
    localparam int unsigned DefAddrWidth  = 11;
    localparam int unsigned DefCntWidth   = 20;
    localparam int unsigned DefSumWidth   = 32;
    localparam int unsigned DefNumChunks  = DefMdataWidth / DefScanWidth;

    // Bits needed to hold a popcount of 0..sw.
    function automatic int unsigned pop_width(input int unsigned sw);
        return $clog2(sw + 1);
    endfunction

    // Bits needed to hold the sum 0 + 1 + ... + (sw - 1).
    function automatic int unsigned wsum_width(input int unsigned sw);
        return $clog2(sw * (sw - 1) / 2 + 1);
    endfunction

endpackage

// File: rtl/dark_chunk_sum.sv
// Combinational reduction of one bitmap chunk.
// Optional feature macro: PUPIL_CENTROID_BBOX_EN (adds first/last-one outputs).
// Ports:
//   chunk    - SCAN_WIDTH-bit slice of the dark-pixel bitmap
//   pop      - number of set bits
//   wsum     - sum of the indices of the set bits
//   has_one  - any bit set                     (bbox build only)
//   first    - index of the lowest set bit     (bbox build only)
//   last     - index of the highest set bit    (bbox build only)
module dark_chunk_sum
    import eyetracker_pkg::*;
#(
    parameter int unsigned SCAN_WIDTH = DefScanWidth,
    localparam int unsigned PopW      = pop_width(SCAN_WIDTH),
    localparam int unsigned WsumW     = wsum_width(SCAN_WIDTH),
    localparam int unsigned IdxW      = $clog2(SCAN_WIDTH)
) (
    input  logic [SCAN_WIDTH-1:0] chunk,
    output logic [PopW-1:0]       pop,
    output logic [WsumW-1:0]      wsum
`ifdef PUPIL_CENTROID_BBOX_EN
    ,
    output logic                  has_one,
    output logic [IdxW-1:0]       first,
    output logic [IdxW-1:0]       last
`endif
);

    always_comb begin
        pop  = '0;
        wsum = '0;
        for (int j = 0; j < int'(SCAN_WIDTH); j++) begin
            if (chunk[j]) begin
                pop  = pop + PopW'(1);
                wsum = wsum + WsumW'(j);
            end
        end
    end

`ifdef PUPIL_CENTROID_BBOX_EN
    assign has_one = |chunk;

    // Downward scan leaves the lowest set index; upward scan the highest.
    always_comb begin
        first = '0;
        last  = '0;
        for (int j = int'(SCAN_WIDTH) - 1; j >= 0; j--) begin
            if (chunk[j]) first = IdxW'(j);
        end
        for (int j = 0; j < int'(SCAN_WIDTH); j++) begin
            if (chunk[j]) last = IdxW'(j);
        end
    end
`endif

endmodule

// File: rtl/pupil_centroid_acc.sv
// Dark-pixel centroid accumulator.
// Snapshots each binarized row, scans it SCAN_WIDTH bits per cycle and
// accumulates count, sum-x and sum-y for the frame; totals are published
// through a valid/ready result port at frame end.
// Optional feature macro: PUPIL_CENTROID_BBOX_EN (bounding-box outputs).
// Ports:
//   CCLK, RST              - clock, synchronous active-high reset
//   iFRAME_START/END       - frame boundary pulses
//   iROW_VALID/IDX/BITS    - completed row bitmap and its y index
//   oRES_VALID/iRES_READY  - result handshake
//   oRES_COUNT/SUMX/SUMY   - published totals; oRES_EMPTY when count is 0
//   oRES_XMIN..oRES_YMAX   - published bounding box (bbox build only)
//   oROW_DROP              - sticky per frame, a row arrived while busy
//   oRES_LOST              - pulse, an unaccepted result was overwritten
//   oBUSY                  - scanning a row
module pupil_centroid_acc
    import eyetracker_pkg::*;
#(
    parameter int unsigned MDATA_WIDTH = DefMdataWidth,
    parameter int unsigned SCAN_WIDTH  = DefScanWidth,
    parameter int unsigned ADDR_WIDTH  = DefAddrWidth,
    parameter int unsigned CNT_WIDTH   = DefCntWidth,
    parameter int unsigned SUM_WIDTH   = DefSumWidth
) (
    input  logic                   CCLK,
    input  logic                   RST,
    input  logic                   iFRAME_START,
    input  logic                   iFRAME_END,
    input  logic                   iROW_VALID,
    input  logic [ADDR_WIDTH-1:0]  iROW_IDX,
    input  logic [MDATA_WIDTH-1:0] iROW_BITS,
    output logic                   oRES_VALID,
    input  logic                   iRES_READY,
    output logic [CNT_WIDTH-1:0]   oRES_COUNT,
    output logic [SUM_WIDTH-1:0]   oRES_SUMX,
    output logic [SUM_WIDTH-1:0]   oRES_SUMY,
    output logic                   oRES_EMPTY,
    output logic                   oROW_DROP,
    output logic                   oRES_LOST,
    output logic                   oBUSY
`ifdef PUPIL_CENTROID_BBOX_EN
    ,
    output logic [ADDR_WIDTH-1:0]  oRES_XMIN,
    output logic [ADDR_WIDTH-1:0]  oRES_XMAX,
    output logic [ADDR_WIDTH-1:0]  oRES_YMIN,
    output logic [ADDR_WIDTH-1:0]  oRES_YMAX
`endif
);

    localparam int unsigned NumChunks = MDATA_WIDTH / SCAN_WIDTH;
    localparam int unsigned KW        = (NumChunks > 1) ? $clog2(NumChunks) : 1;
    localparam int unsigned PopW      = pop_width(SCAN_WIDTH);
    localparam int unsigned WsumW     = wsum_width(SCAN_WIDTH);
    localparam int unsigned IdxW      = $clog2(SCAN_WIDTH);

    state_e                 state_q, state_d;
    logic [KW-1:0]          k_q, k_d;
    logic [MDATA_WIDTH-1:0] buf_q, buf_d;
    logic [ADDR_WIDTH-1:0]  row_q, row_d;
    logic                   end_pending_q, end_pending_d;
    logic [CNT_WIDTH-1:0]   count_q, count_d;
    logic [SUM_WIDTH-1:0]   sumx_q, sumx_d, sumy_q, sumy_d;
    logic                   drop_q, drop_d;
    logic                   res_valid_q, res_valid_d;
    logic [CNT_WIDTH-1:0]   res_count_q, res_count_d;
    logic [SUM_WIDTH-1:0]   res_sumx_q, res_sumx_d, res_sumy_q, res_sumy_d;
    logic                   res_empty_q, res_empty_d;
    logic                   lost_q, lost_d;

    logic [SCAN_WIDTH-1:0]  chunk;
    logic [PopW-1:0]        pop;
    logic [WsumW-1:0]       wsum;

    assign chunk = buf_q[k_q*SCAN_WIDTH +: SCAN_WIDTH];

`ifdef PUPIL_CENTROID_BBOX_EN
    logic                  has_one;
    logic [IdxW-1:0]       first, last;
    logic [ADDR_WIDTH-1:0] x_first, x_last;
    logic [ADDR_WIDTH-1:0] xmin_q, xmin_d, xmax_q, xmax_d, ymin_q, ymin_d, ymax_q, ymax_d;
    logic [ADDR_WIDTH-1:0] rxmin_q, rxmin_d, rxmax_q, rxmax_d;
    logic [ADDR_WIDTH-1:0] rymin_q, rymin_d, rymax_q, rymax_d;

    // SCAN_WIDTH is a power of two, so {k, bit} is k*SCAN_WIDTH + bit.
    assign x_first = ADDR_WIDTH'({k_q, first});
    assign x_last  = ADDR_WIDTH'({k_q, last});
`endif

    dark_chunk_sum #(
        .SCAN_WIDTH(SCAN_WIDTH)
    ) u_chunk (
        .chunk   (chunk),
        .pop     (pop),
        .wsum    (wsum)
`ifdef PUPIL_CENTROID_BBOX_EN
        ,
        .has_one (has_one),
        .first   (first),
        .last    (last)
`endif
    );

    always_comb begin
        state_d       = state_q;
        k_d           = k_q;
        buf_d         = buf_q;
        row_d         = row_q;
        end_pending_d = end_pending_q;
        count_d       = count_q;
        sumx_d        = sumx_q;
        sumy_d        = sumy_q;
        drop_d        = drop_q;
        res_valid_d   = res_valid_q;
        res_count_d   = res_count_q;
        res_sumx_d    = res_sumx_q;
        res_sumy_d    = res_sumy_q;
        res_empty_d   = res_empty_q;
        lost_d        = 1'b0;
`ifdef PUPIL_CENTROID_BBOX_EN
        xmin_d  = xmin_q;
        xmax_d  = xmax_q;
        ymin_d  = ymin_q;
        ymax_d  = ymax_q;
        rxmin_d = rxmin_q;
        rxmax_d = rxmax_q;
        rymin_d = rymin_q;
        rymax_d = rymax_q;
`endif

        if (res_valid_q && iRES_READY) res_valid_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (iROW_VALID) begin
                    buf_d   = iROW_BITS;
                    row_d   = iROW_IDX;
                    k_d     = '0;
                    state_d = StScan;
                    // A coincident frame end waits for this row to finish.
                    if (iFRAME_END) end_pending_d = 1'b1;
                end else if (iFRAME_END) begin
                    state_d = StPublish;
                end
            end
            StScan: begin
                count_d = count_q + CNT_WIDTH'(pop);
                sumx_d  = sumx_q + SUM_WIDTH'(k_q) * SUM_WIDTH'(SCAN_WIDTH) * SUM_WIDTH'(pop)
                        + SUM_WIDTH'(wsum);
                sumy_d  = sumy_q + SUM_WIDTH'(row_q) * SUM_WIDTH'(pop);
`ifdef PUPIL_CENTROID_BBOX_EN
                if (has_one) begin
                    if (x_first < xmin_q) xmin_d = x_first;
                    if (x_last > xmax_q)  xmax_d = x_last;
                    if (row_q < ymin_q)   ymin_d = row_q;
                    if (row_q > ymax_q)   ymax_d = row_q;
                end
`endif
                k_d = k_q + KW'(1);
                if (iFRAME_END) end_pending_d = 1'b1;
                if (k_q == KW'(NumChunks - 1)) begin
                    state_d = (end_pending_q || iFRAME_END) ? StPublish : StIdle;
                end
            end
            StPublish: begin
                res_count_d   = count_q;
                res_sumx_d    = sumx_q;
                res_sumy_d    = sumy_q;
                res_empty_d   = (count_q == '0);
                res_valid_d   = 1'b1;
                lost_d        = res_valid_q && !iRES_READY;
                end_pending_d = 1'b0;
                state_d       = StIdle;
`ifdef PUPIL_CENTROID_BBOX_EN
                rxmin_d = xmin_q;
                rxmax_d = xmax_q;
                rymin_d = ymin_q;
                rymax_d = ymax_q;
`endif
            end
            default: state_d = StIdle;
        endcase

        if (iROW_VALID && state_q != StIdle) drop_d = 1'b1;

        // Frame start wins over accumulation; a row accepted in IDLE this
        // same cycle is still taken and scanned into the cleared totals.
        if (iFRAME_START) begin
            count_d       = '0;
            sumx_d        = '0;
            sumy_d        = '0;
            end_pending_d = 1'b0;
            drop_d        = iROW_VALID && (state_q != StIdle);
            if (state_q == StScan) state_d = StIdle;
`ifdef PUPIL_CENTROID_BBOX_EN
            xmin_d = '1;
            xmax_d = '0;
            ymin_d = '1;
            ymax_d = '0;
`endif
        end
    end

    always_ff @(posedge CCLK) begin
        if (RST) begin
            state_q       <= StIdle;
            k_q           <= '0;
            buf_q         <= '0;
            row_q         <= '0;
            end_pending_q <= 1'b0;
            count_q       <= '0;
            sumx_q        <= '0;
            sumy_q        <= '0;
            drop_q        <= 1'b0;
            res_valid_q   <= 1'b0;
            res_count_q   <= '0;
            res_sumx_q    <= '0;
            res_sumy_q    <= '0;
            res_empty_q   <= 1'b0;
            lost_q        <= 1'b0;
`ifdef PUPIL_CENTROID_BBOX_EN
            // Min trackers start at their cleared value so a frame with no
            // preceding start pulse still tracks correctly.
            xmin_q  <= '1;
            xmax_q  <= '0;
            ymin_q  <= '1;
            ymax_q  <= '0;
            rxmin_q <= '0;
            rxmax_q <= '0;
            rymin_q <= '0;
            rymax_q <= '0;
`endif
        end else begin
            state_q       <= state_d;
            k_q           <= k_d;
            buf_q         <= buf_d;
            row_q         <= row_d;
            end_pending_q <= end_pending_d;
            count_q       <= count_d;
            sumx_q        <= sumx_d;
            sumy_q        <= sumy_d;
            drop_q        <= drop_d;
            res_valid_q   <= res_valid_d;
            res_count_q   <= res_count_d;
            res_sumx_q    <= res_sumx_d;
            res_sumy_q    <= res_sumy_d;
            res_empty_q   <= res_empty_d;
            lost_q        <= lost_d;
`ifdef PUPIL_CENTROID_BBOX_EN
            xmin_q  <= xmin_d;
            xmax_q  <= xmax_d;
            ymin_q  <= ymin_d;
            ymax_q  <= ymax_d;
            rxmin_q <= rxmin_d;
            rxmax_q <= rxmax_d;
            rymin_q <= rymin_d;
            rymax_q <= rymax_d;
`endif
        end
    end

    assign oRES_VALID = res_valid_q;
    assign oRES_COUNT = res_count_q;
    assign oRES_SUMX  = res_sumx_q;
    assign oRES_SUMY  = res_sumy_q;
    assign oRES_EMPTY = res_empty_q;
    assign oROW_DROP  = drop_q;
    assign oRES_LOST  = lost_q;
    assign oBUSY      = (state_q == StScan);
`ifdef PUPIL_CENTROID_BBOX_EN
    assign oRES_XMIN = rxmin_q;
    assign oRES_XMAX = rxmax_q;
    assign oRES_YMIN = rymin_q;
    assign oRES_YMAX = rymax_q;
`endif

endmodule
